// File: rtl/bcd_alu_arbiter.sv
// bcd_alu_arbiter: round-robin front end that shares one combinational BCD ALU
// between two requesters. A winning request is latched onto the ALU inputs.
// The ALU is given ALU_LAT cycles to settle. The result is then returned to
// the granted port over a valid/ready response channel.
module bcd_alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid0,
  input  logic [1:0]  req_op0,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_b0,
  output logic        req_ready0,
  output logic        rsp_valid0,
  output logic [15:0] rsp_data0,
  output logic        rsp_err0,
  input  logic        rsp_ready0,
  input  logic        req_valid1,
  input  logic [1:0]  req_op1,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b1,
  output logic        req_ready1,
  output logic        rsp_valid1,
  output logic [15:0] rsp_data1,
  output logic        rsp_err1,
  input  logic        rsp_ready1,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_c,
  output logic        busy,
  output logic        grant_id
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            r_state, w_next;
  logic              r_gnt;          // doubles as the round-robin pointer
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_op;
  logic [15:0]       r_a, r_b;
  logic [1:0]        r_rsp_valid, r_rsp_err;
  logic [1:0][15:0]  r_rsp_data;

  logic [1:0]        w_req_valid, w_req_ready, w_rsp_ready;
  logic              w_win, w_accept, w_done, w_rsp_hs;

  assign w_req_valid = {req_valid1, req_valid0};
  assign w_rsp_ready = {rsp_ready1, rsp_ready0};
  // On a tie the port that did not own the last operation wins.
  assign w_win    = (&w_req_valid) ? ~r_gnt : req_valid1;
  assign w_accept = (r_state == IDLE) && (|w_req_valid);
  assign w_done   = (r_state == EXEC) && (r_cnt == '0);
  assign w_rsp_hs = (r_state == RESP) && w_rsp_ready[r_gnt];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    if (w_done)   w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state: request ready goes only to the IDLE winner
  always_comb begin
    w_req_ready = '0;
    if (w_accept) w_req_ready[w_win] = 1'b1;
    busy = (r_state != IDLE);
  end

  // Operand latch, settle counter and per-port response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt       <= 1'b1;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_gnt <= w_win;
        r_cnt <= CW'(ALU_LAT - 1);
        r_op  <= w_win ? req_op1 : req_op0;
        r_a   <= w_win ? req_a1  : req_a0;
        r_b   <= w_win ? req_b1  : req_b0;
      end
      if (r_state == EXEC && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_done) begin
        r_rsp_data[r_gnt]  <= alu_c;
        r_rsp_err[r_gnt]   <= (alu_c == 16'hCCCC);
        r_rsp_valid[r_gnt] <= 1'b1;
      end
      if (w_rsp_hs) r_rsp_valid[r_gnt] <= 1'b0;
    end
  end

  assign req_ready0 = w_req_ready[0];
  assign req_ready1 = w_req_ready[1];
  assign rsp_valid0 = r_rsp_valid[0];
  assign rsp_valid1 = r_rsp_valid[1];
  assign rsp_data0  = r_rsp_data[0];
  assign rsp_data1  = r_rsp_data[1];
  assign rsp_err0   = r_rsp_err[0];
  assign rsp_err1   = r_rsp_err[1];
  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign grant_id   = r_gnt;

endmodule
